stream_fifo_arbiter: RTL and testbench
======================================

Name: stream_fifo_arbiter

Overview:
- Round-robin arbiter that merges up to NUM_SRC 32-bit first-word-fall-through data sources into the single read-side stream consumed by the BRAM output FIFO (bram_fifo FIFO_READ_NEXT_OUT / FIFO_EMPTY_IN / FIFO_DATA).
- Sits between the data-producing cores and the BRAM FIFO in the Ethernet readout path.
- Holds each grant for a bounded burst, so one busy source cannot starve the others.
- Optionally tags each word with its source index.

Parameters:
- NUM_SRC, 4: number of sources, 2..16.
- MAX_BURST, 16: maximum words taken per grant, 1..65535.
- TAG_EN, 0: when 1, the top IDW bits of each output word are replaced by the source index.
- IDW, clog2(NUM_SRC) (localparam): width of the source index.

Ports:
- BUS_CLK  in  1  sole clock.
- RESET_N  in  1  asynchronous, active-low reset.
- SRC_EN  in  NUM_SRC  per-source enable mask.
- SRC_EMPTY  in  NUM_SRC  per-source FWFT empty flag.
- SRC_DATA  in  32*NUM_SRC  source data; source i occupies [32*i+:32].
- SRC_READ  out  NUM_SRC  per-source read strobe; asserting it consumes the current word.
- FIFO_READ_NEXT_OUT  in  1  downstream pops the current word this cycle.
- FIFO_EMPTY_OUT  out  1  high = no valid word on FIFO_DATA_OUT.
- FIFO_DATA_OUT  out  32  muxed, optionally tagged, word.
- GRANT_ID  out  IDW  index of the current or last granted source.
- BUSY  out  1  a grant is active.

Behaviour:
- Reset values: state IDLE, GRANT_ID=0, BUSY=0, burst count 0, last pointer = NUM_SRC-1, SRC_READ=0, FIFO_EMPTY_OUT=1, FIFO_DATA_OUT=0.
- Request vector: req[i] = SRC_EN[i] & ~SRC_EMPTY[i].
- FSM, two states:
  - IDLE: if any req is set, pick the first set req at or after (last+1) mod NUM_SRC, wrapping. Register it into GRANT_ID, clear the burst count, go to GRANT. No reads occur in IDLE.
  - GRANT (BUSY=1):
    - Datapath is combinational pass-through from the granted source, zero latency:
      - FIFO_EMPTY_OUT = SRC_EMPTY[g] | ~SRC_EN[g]
      - FIFO_DATA_OUT = SRC_DATA[g], tagged if TAG_EN
      - SRC_READ[g] = FIFO_READ_NEXT_OUT & ~FIFO_EMPTY_OUT; all other SRC_READ bits are 0
    - Each pop increments the burst count.
    - Release to IDLE at the clock edge when any of these holds:
      - the count reaches MAX_BURST (including the pop in this cycle), or
      - the granted source is empty or disabled this cycle, or
      - a pop empties it (observed as empty on the next cycle, which releases then).
    - On release, last is set to g.
- Switch cost: exactly one IDLE cycle between grants. Back-to-back grants to the same source are allowed only if no other source is requesting.
- Tagging: when TAG_EN=1, FIFO_DATA_OUT[31:32-IDW] = g and the lower bits pass through unchanged. When TAG_EN=0, data is untouched.
- FIFO_READ_NEXT_OUT while FIFO_EMPTY_OUT=1 is ignored: no SRC_READ, no count change.
- SRC_EN deasserted mid-burst:
  - FIFO_EMPTY_OUT goes high combinationally in that same cycle.
  - No further reads occur.
  - The grant releases at the next edge.
  - Words already popped are not lost.
- MAX_BURST=1: strict round-robin, one word per grant.
- RESET_N low at any time returns all registers to reset values immediately. An in-flight pop is not counted. Downstream sees FIFO_EMPTY_OUT=1 asynchronously.
- Burst counter width is clog2(MAX_BURST+1); it saturates and never wraps.

Decomposition:
- Shared package arb_pkg: IDW/clog2 function, FSM state encoding (IDLE, GRANT), width constant 32.
- One sub-module, rr_pick: combinational round-robin first-set-after-pointer search. Inputs req[NUM_SRC] and last[IDW]; outputs idx[IDW] and any. Reused by other arbiters.

Test Plan:
- Single source: NUM_SRC=4, source 2 holds 5 words, downstream always pops.
  - Required: IDLE 1 cycle, then 5 consecutive pops with SRC_READ=4'b0100.
  - Then FIFO_EMPTY_OUT=1, back to IDLE, GRANT_ID=2.
- Burst limit: MAX_BURST=4, sources 0 and 1 each hold 10 words.
  - Required output order: 4×src0, idle, 4×src1, idle, 4×src0, idle, 4×src1, idle, 2×src0, idle, 2×src1.
  - Total 20 words, none duplicated.
- Wrap-around fairness: last=3, requests from sources 0 and 3.
  - Required: next grant is 0, then 3.
  - With requests from source 1 only after a grant to 1, source 1 is regranted.
- Backpressure: FIFO_READ_NEXT_OUT toggles 1,0,1,0.
  - Required: SRC_READ pulses only on the 1-cycles.
  - Burst count advances only on pops; data stays stable while not popped.
- Disable mid-burst and tagging: TAG_EN=1; SRC_EN[1] cleared after 2 of 8 words.
  - Required: FIFO_EMPTY_OUT=1 in that same cycle and release next cycle.
  - Output words carry bits[31:30]=2'b01.
- Reset mid-burst: RESET_N=0 during a grant.
  - Required: SRC_READ=0 and FIFO_EMPTY_OUT=1 immediately.
  - After release, arbitration restarts from source 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the stream arbiters: data width, FSM encoding and
// the ceiling-log2 helper used to size index and counter fields.
package arb_pkg;

   localparam int DATA_W = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first set request strictly after the last pointer,
// wrapping, so the last winner gets the lowest priority.
module rr_pick #(
   parameter int NUM_SRC = 4,
   parameter int IDW     = 2
) (
   input  logic [NUM_SRC-1:0] req,
   input  logic [IDW-1:0]     last,
   output logic [IDW-1:0]     idx,
   output logic               any
);

   logic [IDW-1:0] cand;
   logic           found;

   always_comb begin
      idx   = '0;
      found = 1'b0;
      cand  = '0;
      for (int k = 1; k <= NUM_SRC; k++) begin
         cand = IDW'((int'(last) + k) % NUM_SRC);
         if (!found && req[cand]) begin
            idx   = cand;
            found = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/stream_fifo_arbiter.sv
// Merges NUM_SRC first-word-fall-through sources into one FWFT stream with
// round-robin grants capped at MAX_BURST words and optional source tagging.
//
//   state | meaning
//   IDLE  | no grant; pick next requester after last, no reads
//   GRANT | zero-latency pass-through from source grant_id
module stream_fifo_arbiter import arb_pkg::*; #(
   parameter int  NUM_SRC   = 4,
   parameter int  MAX_BURST = 16,
   parameter bit  TAG_EN    = 1'b0,
   localparam int IDW       = clog2(NUM_SRC)
) (
   input  logic                      BUS_CLK,
   input  logic                      RESET_N,
   input  logic [NUM_SRC-1:0]        SRC_EN,
   input  logic [NUM_SRC-1:0]        SRC_EMPTY,
   input  logic [DATA_W*NUM_SRC-1:0] SRC_DATA,
   output logic [NUM_SRC-1:0]        SRC_READ,
   input  logic                      FIFO_READ_NEXT_OUT,
   output logic                      FIFO_EMPTY_OUT,
   output logic [DATA_W-1:0]         FIFO_DATA_OUT,
   output logic [IDW-1:0]            GRANT_ID,
   output logic                      BUSY
);

   localparam int CW = clog2(MAX_BURST + 1);

   arb_state_e        state;
   logic              busy;
   logic [IDW-1:0]    grant_id;
   logic [IDW-1:0]    last;
   logic [CW-1:0]     burst_cnt;
   logic [NUM_SRC-1:0] req;
   logic [IDW-1:0]    pick_idx;
   logic              pick_any;
   logic              cur_empty;
   logic              pop;
   logic              at_limit;
   logic [DATA_W-1:0] src_words [NUM_SRC];

   assign req = SRC_EN & ~SRC_EMPTY;

   for (genvar i = 0; i < NUM_SRC; i++) begin : g_words
      assign src_words[i] = SRC_DATA[DATA_W*i +: DATA_W];
   end

   rr_pick #(.NUM_SRC(NUM_SRC), .IDW(IDW)) u_pick (
      .req  (req),
      .last (last),
      .idx  (pick_idx),
      .any  (pick_any)
   );

   // busy is part of the empty term so reset forces the stream empty at once
   assign cur_empty = ~busy | SRC_EMPTY[grant_id] | ~SRC_EN[grant_id];
   assign pop       = FIFO_READ_NEXT_OUT & ~cur_empty;
   assign at_limit  = ({1'b0, burst_cnt} + (CW+1)'(1)) >= (CW+1)'(MAX_BURST);

   always_comb begin
      FIFO_EMPTY_OUT     = cur_empty;
      SRC_READ           = '0;
      SRC_READ[grant_id] = pop;
      FIFO_DATA_OUT      = busy ? src_words[grant_id] : '0;
      if (TAG_EN && busy) FIFO_DATA_OUT[DATA_W-1 -: IDW] = grant_id;
   end

   always_ff @(posedge BUS_CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state     <= IDLE;
         busy      <= 1'b0;
         grant_id  <= '0;
         last      <= IDW'(NUM_SRC - 1);
         burst_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_any) begin
                  state     <= GRANT;
                  busy      <= 1'b1;
                  grant_id  <= pick_idx;
                  burst_cnt <= '0;
               end
            end
            GRANT: begin
               if (pop && burst_cnt != CW'(MAX_BURST)) burst_cnt <= burst_cnt + CW'(1);
               if ((pop && at_limit) || cur_empty) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  last  <= grant_id;
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign GRANT_ID = grant_id;
   assign BUSY     = busy;

endmodule

// File: tb/tb_stream_fifo_arbiter.sv
// Directed bench for stream_fifo_arbiter: instance a (burst 16, untagged) and
// instance b (burst 4, tagged) share the modelled sources; sel picks the one under test.
module tb_stream_fifo_arbiter;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [3:0]   src_en;
   logic [3:0]   src_empty;
   logic [127:0] src_data;
   logic         pop;
   logic         sel;

   logic [3:0]  read_a, read_b, rd_s;
   logic        empty_a, empty_b, emp_s;
   logic [31:0] data_a, data_b, dat_s;
   logic [1:0]  gid_a, gid_b, gid_s;
   logic        busy_a, busy_b, busy_s;

   int rd [4];
   int wr [4];
   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   stream_fifo_arbiter #(.NUM_SRC(4), .MAX_BURST(16), .TAG_EN(1'b0)) u_dut_a (
      .BUS_CLK(clk), .RESET_N(rst_n), .SRC_EN(src_en), .SRC_EMPTY(src_empty),
      .SRC_DATA(src_data), .SRC_READ(read_a), .FIFO_READ_NEXT_OUT(pop),
      .FIFO_EMPTY_OUT(empty_a), .FIFO_DATA_OUT(data_a), .GRANT_ID(gid_a), .BUSY(busy_a)
   );

   stream_fifo_arbiter #(.NUM_SRC(4), .MAX_BURST(4), .TAG_EN(1'b1)) u_dut_b (
      .BUS_CLK(clk), .RESET_N(rst_n), .SRC_EN(src_en), .SRC_EMPTY(src_empty),
      .SRC_DATA(src_data), .SRC_READ(read_b), .FIFO_READ_NEXT_OUT(pop),
      .FIFO_EMPTY_OUT(empty_b), .FIFO_DATA_OUT(data_b), .GRANT_ID(gid_b), .BUSY(busy_b)
   );

   always_comb begin
      rd_s   = sel ? read_b  : read_a;
      emp_s  = sel ? empty_b : empty_a;
      dat_s  = sel ? data_b  : data_a;
      gid_s  = sel ? gid_b   : gid_a;
      busy_s = sel ? busy_b  : busy_a;
   end

   function automatic logic [31:0] word(input int s, input int k);
      return 32'hC000_0000 | (32'(s) << 12) | 32'(k);
   endfunction

   function automatic logic [31:0] tagw(input int s, input int k);
      logic [31:0] w;
      w = word(s, k);
      w[31:30] = s[1:0];
      return w;
   endfunction

   task automatic drive_src();
      for (int i = 0; i < 4; i++) begin
         src_empty[i] = (rd[i] >= wr[i]);
         src_data[32*i +: 32] = word(i, rd[i]);
      end
   endtask

   task automatic load(input int s, input int n);
      wr[s] += n;
      drive_src();
      #1;
   endtask

   // called at a negedge: commit this cycle's reads to the model, return at the next negedge
   task automatic advance();
      logic [3:0] r;
      r = rd_s;
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) if (r[i]) rd[i]++;
      drive_src();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n  = 1'b0;
      pop    = 1'b0;
      src_en = 4'hF;
      for (int i = 0; i < 4; i++) begin
         rd[i] = 0;
         wr[i] = 0;
      end
      drive_src();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      do_reset();
      rst_n = 1'b0;
      pop   = 1'b1;
      load(0, 3);
      total++; if (busy_a !== 1'b0)       begin bad++; $display("FAIL reset_busy_a got=%0b want=0", busy_a); end
      total++; if (gid_a !== 2'd0)        begin bad++; $display("FAIL reset_gid_a got=%0d want=0", gid_a); end
      total++; if (read_a !== 4'b0000)    begin bad++; $display("FAIL reset_read_a got=%b want=0000", read_a); end
      total++; if (empty_a !== 1'b1)      begin bad++; $display("FAIL reset_empty_a got=%0b want=1", empty_a); end
      total++; if (data_a !== 32'h0)      begin bad++; $display("FAIL reset_data_a got=%h want=0", data_a); end
      total++; if (busy_b !== 1'b0)       begin bad++; $display("FAIL reset_busy_b got=%0b want=0", busy_b); end
      total++; if (read_b !== 4'b0000)    begin bad++; $display("FAIL reset_read_b got=%b want=0000", read_b); end
      total++; if (empty_b !== 1'b1)      begin bad++; $display("FAIL reset_empty_b got=%0b want=1", empty_b); end
      total++; if (data_b !== 32'h0)      begin bad++; $display("FAIL reset_data_b got=%h want=0", data_b); end
   endtask

   task automatic test_single_source();
      sel = 1'b0;
      do_reset();
      load(2, 5);
      pop = 1'b1;
      #1;
      total++; if (busy_s !== 1'b0)    begin bad++; $display("FAIL single_idle_busy got=%0b want=0", busy_s); end
      total++; if (rd_s !== 4'b0000)   begin bad++; $display("FAIL single_idle_read got=%b want=0000", rd_s); end
      advance();
      for (int k = 0; k < 5; k++) begin
         total++; if (busy_s !== 1'b1)    begin bad++; $display("FAIL single_busy[%0d] got=%0b want=1", k, busy_s); end
         total++; if (gid_s !== 2'd2)     begin bad++; $display("FAIL single_gid[%0d] got=%0d want=2", k, gid_s); end
         total++; if (rd_s !== 4'b0100)   begin bad++; $display("FAIL single_read[%0d] got=%b want=0100", k, rd_s); end
         total++; if (dat_s !== word(2, k)) begin bad++; $display("FAIL single_data[%0d] got=%h want=%h", k, dat_s, word(2, k)); end
         advance();
      end
      total++; if (emp_s !== 1'b1)     begin bad++; $display("FAIL single_drained_empty got=%0b want=1", emp_s); end
      total++; if (rd_s !== 4'b0000)   begin bad++; $display("FAIL single_drained_read got=%b want=0000", rd_s); end
      advance();
      total++; if (busy_s !== 1'b0)    begin bad++; $display("FAIL single_release_busy got=%0b want=0", busy_s); end
      total++; if (gid_s !== 2'd2)     begin bad++; $display("FAIL single_release_gid got=%0d want=2", gid_s); end
      total++; if (emp_s !== 1'b1)     begin bad++; $display("FAIL single_release_empty got=%0b want=1", emp_s); end
   endtask

   task automatic test_burst_limit();
      int n, idle_run, exp_s, exp_gap, kk, k0, k1;
      sel = 1'b1;
      do_reset();
      load(0, 10);
      load(1, 10);
      pop = 1'b1;
      #1;
      n = 0; idle_run = 0; k0 = 0; k1 = 0;
      for (int c = 0; c < 80 && n < 20; c++) begin
         if (rd_s != 4'b0000) begin
            exp_s   = (n < 4) ? 0 : (n < 8) ? 1 : (n < 12) ? 0 : (n < 16) ? 1 : (n < 18) ? 0 : 1;
            exp_gap = (n == 4 || n == 8 || n == 12 || n == 16) ? 1 : (n == 18) ? 2 : 0;
            kk      = (exp_s == 0) ? k0 : k1;
            total++; if (rd_s !== 4'(1 << exp_s)) begin bad++; $display("FAIL burst_read[%0d] got=%b want_src=%0d", n, rd_s, exp_s); end
            total++; if (dat_s !== tagw(exp_s, kk)) begin bad++; $display("FAIL burst_data[%0d] got=%h want=%h", n, dat_s, tagw(exp_s, kk)); end
            if (n > 0) begin
               total++; if (idle_run !== exp_gap) begin bad++; $display("FAIL burst_gap[%0d] got=%0d want=%0d", n, idle_run, exp_gap); end
            end
            if (exp_s == 0) k0++; else k1++;
            n++;
            idle_run = 0;
         end else if (n > 0) begin
            idle_run++;
         end
         advance();
      end
      total++; if (n !== 20)     begin bad++; $display("FAIL burst_word_count got=%0d want=20", n); end
      total++; if (rd[0] !== 10) begin bad++; $display("FAIL burst_src0_drained got=%0d want=10", rd[0]); end
      total++; if (rd[1] !== 10) begin bad++; $display("FAIL burst_src1_drained got=%0d want=10", rd[1]); end
   endtask

   task automatic test_wrap_fairness();
      sel = 1'b0;
      do_reset();
      load(0, 1);
      load(3, 1);
      pop = 1'b1;
      #1;
      advance();
      total++; if (gid_s !== 2'd0)    begin bad++; $display("FAIL wrap_first_gid got=%0d want=0", gid_s); end
      total++; if (rd_s !== 4'b0001)  begin bad++; $display("FAIL wrap_first_read got=%b want=0001", rd_s); end
      advance();
      total++; if (emp_s !== 1'b1)    begin bad++; $display("FAIL wrap_src0_empty got=%0b want=1", emp_s); end
      advance();
      total++; if (busy_s !== 1'b0)   begin bad++; $display("FAIL wrap_switch_idle got=%0b want=0", busy_s); end
      advance();
      total++; if (gid_s !== 2'd3)    begin bad++; $display("FAIL wrap_second_gid got=%0d want=3", gid_s); end
      total++; if (rd_s !== 4'b1000)  begin bad++; $display("FAIL wrap_second_read got=%b want=1000", rd_s); end
      advance();
      advance();
      load(1, 1);
      advance();
      total++; if (gid_s !== 2'd1 || busy_s !== 1'b1) begin bad++; $display("FAIL wrap_src1_grant got=%0d/%0b want=1/1", gid_s, busy_s); end
      advance();
      advance();
      load(1, 1);
      total++; if (busy_s !== 1'b0)   begin bad++; $display("FAIL wrap_regrant_idle got=%0b want=0", busy_s); end
      advance();
      total++; if (gid_s !== 2'd1 || busy_s !== 1'b1) begin bad++; $display("FAIL wrap_regrant got=%0d/%0b want=1/1", gid_s, busy_s); end
      total++; if (rd_s !== 4'b0010)  begin bad++; $display("FAIL wrap_regrant_read got=%b want=0010", rd_s); end
   endtask

   task automatic test_backpressure();
      sel = 1'b1;
      do_reset();
      load(1, 6);
      pop = 1'b1;
      #1;
      advance();
      for (int c = 0; c < 7; c++) begin
         pop = (c % 2 == 0);
         #1;
         total++; if (busy_s !== 1'b1) begin bad++; $display("FAIL bp_busy[%0d] got=%0b want=1", c, busy_s); end
         total++; if (rd_s !== ((c % 2 == 0) ? 4'b0010 : 4'b0000)) begin bad++; $display("FAIL bp_read[%0d] got=%b pop=%0b", c, rd_s, pop); end
         total++; if (dat_s !== tagw(1, (c + 1) / 2)) begin bad++; $display("FAIL bp_data[%0d] got=%h want=%h", c, dat_s, tagw(1, (c + 1) / 2)); end
         advance();
      end
      total++; if (busy_s !== 1'b0) begin bad++; $display("FAIL bp_limit_release got=%0b want=0", busy_s); end
      total++; if (rd[1] !== 4)     begin bad++; $display("FAIL bp_pop_count got=%0d want=4", rd[1]); end
   endtask

   task automatic test_disable_tag();
      sel = 1'b1;
      do_reset();
      load(1, 8);
      pop = 1'b1;
      #1;
      advance();
      for (int k = 0; k < 2; k++) begin
         total++; if (rd_s !== 4'b0010)    begin bad++; $display("FAIL dis_read[%0d] got=%b want=0010", k, rd_s); end
         total++; if (dat_s !== tagw(1, k)) begin bad++; $display("FAIL dis_tag_data[%0d] got=%h want=%h", k, dat_s, tagw(1, k)); end
         advance();
      end
      src_en[1] = 1'b0;
      #1;
      total++; if (emp_s !== 1'b1)     begin bad++; $display("FAIL dis_same_cycle_empty got=%0b want=1", emp_s); end
      total++; if (rd_s !== 4'b0000)   begin bad++; $display("FAIL dis_no_read got=%b want=0000", rd_s); end
      total++; if (busy_s !== 1'b1)    begin bad++; $display("FAIL dis_still_busy got=%0b want=1", busy_s); end
      advance();
      total++; if (busy_s !== 1'b0)    begin bad++; $display("FAIL dis_release got=%0b want=0", busy_s); end
      total++; if (gid_s !== 2'd1)     begin bad++; $display("FAIL dis_gid got=%0d want=1", gid_s); end
      total++; if (rd[1] !== 2)        begin bad++; $display("FAIL dis_popped got=%0d want=2", rd[1]); end
   endtask

   task automatic test_reset_mid_burst();
      sel = 1'b0;
      do_reset();
      load(2, 8);
      pop = 1'b1;
      #1;
      advance();
      total++; if (gid_s !== 2'd2 || rd_s !== 4'b0100) begin bad++; $display("FAIL rst_pre_grant got=%0d/%b want=2/0100", gid_s, rd_s); end
      advance();
      advance();
      load(0, 4);
      #1;
      rst_n = 1'b0;
      #1;
      total++; if (rd_s !== 4'b0000)  begin bad++; $display("FAIL rst_read got=%b want=0000", rd_s); end
      total++; if (emp_s !== 1'b1)    begin bad++; $display("FAIL rst_empty got=%0b want=1", emp_s); end
      total++; if (busy_s !== 1'b0)   begin bad++; $display("FAIL rst_busy got=%0b want=0", busy_s); end
      total++; if (gid_s !== 2'd0)    begin bad++; $display("FAIL rst_gid got=%0d want=0", gid_s); end
      advance();
      rst_n = 1'b1;
      #1;
      total++; if (rd[2] !== 2)       begin bad++; $display("FAIL rst_popped got=%0d want=2", rd[2]); end
      advance();
      total++; if (gid_s !== 2'd0 || busy_s !== 1'b1) begin bad++; $display("FAIL rst_restart got=%0d/%0b want=0/1", gid_s, busy_s); end
      total++; if (rd_s !== 4'b0001)  begin bad++; $display("FAIL rst_restart_read got=%b want=0001", rd_s); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      sel = 1'b0;
      test_reset();
      test_single_source();
      test_burst_limit();
      test_wrap_fairness();
      test_backpressure();
      test_disable_tag();
      test_reset_mid_burst();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
